life_matrix_scan: RTL and testbench

- Downstream display stage for the 64-bit Game-of-Life grid produced by the seed/evolve path.
- Captures a new grid on request into a shadow buffer and promotes it to the display buffer only at a frame boundary, so there is no tearing.
- Time-multiplexes the display buffer onto an 8x8 LED matrix, one row at a time, with a per-row blanking window against ghosting.
- Reports frame completion and a frame count.

---
 rtl/life_matrix_scan_if.sv | 32 +++
 rtl/life_matrix_scan.sv | 181 ++++++++++++++++++
 tb/tb_life_matrix_scan.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/life_matrix_scan_if.sv
// life_matrix_scan_if
//   Signal bundle between the evolve/mux path (master) and the LED matrix
//   scanner (slave). The clock and reset are not part of the bundle.
//
//   grid        [63:0] grid to display; bit (r*8+c) = row r, column c
//   grid_load          one-cycle strobe: capture grid into the shadow buffer
//   enable             1 = scanning, 0 = freeze position and blank the matrix
//   row_sel     [7:0]  one-hot active-high row drive
//   col_out     [7:0]  column data for the active row
//   frame_done         one-cycle pulse after row 7 completes
//   frame_count [15:0] completed frames, wrapping
//   stable             still-life flag (0 unless stable detection is built)
interface life_matrix_scan_if;
  logic [63:0] grid;
  logic        grid_load;
  logic        enable;
  logic [7:0]  row_sel;
  logic [7:0]  col_out;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        stable;

  modport master (
    output grid, grid_load, enable,
    input  row_sel, col_out, frame_done, frame_count, stable
  );

  modport slave (
    input  grid, grid_load, enable,
    output row_sel, col_out, frame_done, frame_count, stable
  );
endinterface

// File: rtl/life_matrix_scan.sv
// life_matrix_scan
//   Display stage for the 64-bit Game-of-Life grid. A requested grid is
//   captured into a shadow buffer and promoted to the front (display) buffer
//   only at a frame boundary, so a frame never shows two different grids.
//   The front buffer is scanned onto an 8x8 LED matrix one row at a time;
//   every row is driven for ROW_CYCLES clocks, the first BLANK_CYCLES of
//   which keep the columns dark to suppress ghosting between rows.
//
// Ports
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset (0 = reset)
//   bus    life_matrix_scan_if.slave: grid / grid_load / enable in,
//          row_sel / col_out / frame_done / frame_count / stable out
//
// Parameters
//   ROW_CYCLES     clocks per row including blanking (>= 2)
//   BLANK_CYCLES   blank clocks at the start of each row (< ROW_CYCLES)
//   STABLE_FRAMES  identical promotions needed before stable asserts
//
// Build option
//   LIFE_MATRIX_STABLE_DETECT_EN  when defined, builds the still-life
//   detector; otherwise stable is tied low and no detector logic exists.
module life_matrix_scan #(
  parameter int ROW_CYCLES    = 1000,
  parameter int BLANK_CYCLES  = 16,
  parameter int STABLE_FRAMES = 8
) (
  input logic               clk,
  input logic               reset,
  life_matrix_scan_if.slave bus
);

  localparam int            DW         = (ROW_CYCLES > 2) ? $clog2(ROW_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(ROW_CYCLES - 1);
  localparam logic [DW-1:0] BLANK_END  = DW'(BLANK_CYCLES);

  // Scan position and buffers
  logic [2:0]    row_idx, row_idx_next;
  logic [DW-1:0] dwell, dwell_next;
  logic [63:0]   shadow, shadow_next;
  logic [63:0]   front, front_next;
  logic          pending, pending_next;

  // Registered outputs
  logic [7:0]    row_sel_q, row_sel_next;
  logic [7:0]    col_out_q, col_out_next;
  logic          frame_done_q, frame_done_next;
  logic [15:0]   frame_count_q, frame_count_next;

  // The last clock of row 7 while scanning; buffers swap on this edge.
  logic          row_end;
  logic          boundary;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    row_end  = bus.enable && (dwell == DWELL_LAST);
    boundary = row_end && (row_idx == 3'd7);

    // Scan position: frozen entirely while enable is low.
    row_idx_next = row_idx;
    dwell_next   = dwell;
    if (bus.enable) begin
      if (row_end) begin
        dwell_next   = '0;
        row_idx_next = row_idx + 3'd1;
      end else begin
        dwell_next = dwell + 1'b1;
      end
    end

    // Buffers. A load that lands exactly on the boundary goes straight to
    // the front buffer; otherwise it waits in the shadow until the next
    // boundary, with the most recent load winning.
    shadow_next  = shadow;
    front_next   = front;
    pending_next = pending;
    if (boundary && bus.grid_load) begin
      front_next   = bus.grid;
      shadow_next  = bus.grid;
      pending_next = 1'b0;
    end else begin
      if (boundary && pending) begin
        front_next   = shadow;
        pending_next = 1'b0;
      end
      if (bus.grid_load) begin
        shadow_next  = bus.grid;
        pending_next = 1'b1;
      end
    end

    // Outputs are produced from the current position and current front
    // buffer; they appear one edge later. The row drive stays on through
    // blanking, only the column data is suppressed.
    row_sel_next = '0;
    col_out_next = '0;
    if (bus.enable) begin
      row_sel_next = 8'h01 << row_idx;
      if (dwell >= BLANK_END) begin
        col_out_next = front[{row_idx, 3'b000} +: 8];
      end
    end

    frame_done_next  = boundary;
    frame_count_next = boundary ? frame_count_q + 16'd1 : frame_count_q;
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values computed above.
  // NOTE: shadow and front are ordinary 64-bit registers, not a memory, and
  // are cleared so a fresh reset always shows a dark matrix until the first
  // promotion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_idx       <= '0;
      dwell         <= '0;
      shadow        <= '0;
      front         <= '0;
      pending       <= 1'b0;
      row_sel_q     <= '0;
      col_out_q     <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      row_idx       <= row_idx_next;
      dwell         <= dwell_next;
      shadow        <= shadow_next;
      front         <= front_next;
      pending       <= pending_next;
      row_sel_q     <= row_sel_next;
      col_out_q     <= col_out_next;
      frame_done_q  <= frame_done_next;
      frame_count_q <= frame_count_next;
    end
  end

  assign bus.row_sel     = row_sel_q;
  assign bus.col_out     = col_out_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_count = frame_count_q;

`ifdef LIFE_MATRIX_STABLE_DETECT_EN
  localparam int            SW         = (STABLE_FRAMES > 0) ? $clog2(STABLE_FRAMES + 1) : 1;
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_FRAMES);

  logic [SW-1:0] still_cnt, still_cnt_next;
  logic          stable_q, stable_next;
  logic          promote;

  // A promotion happens on every boundary that swaps in a grid, whether it
  // came from the shadow or the bypass; front_next is that incoming grid.
  always_comb begin
    promote        = boundary && (bus.grid_load || pending);
    still_cnt_next = still_cnt;
    if (promote) begin
      if (front_next != front) begin
        still_cnt_next = '0;
      end else if (still_cnt != STABLE_MAX) begin
        still_cnt_next = still_cnt + 1'b1;
      end
    end
    stable_next = (still_cnt_next == STABLE_MAX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      still_cnt <= '0;
      stable_q  <= 1'b0;
    end else begin
      still_cnt <= still_cnt_next;
      stable_q  <= stable_next;
    end
  end

  assign bus.stable = stable_q;
`else
  assign bus.stable = 1'b0;
`endif

endmodule

// File: tb/tb_life_matrix_scan.sv
// tb_life_matrix_scan
//   Directed bench for life_matrix_scan with ROW_CYCLES=8, BLANK_CYCLES=2,
//   STABLE_FRAMES=3. A frame is 64 clocks; scan position p = row*8 + dwell.
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_life_matrix_scan;

  localparam int ROWC   = 8;
  localparam int BLANK  = 2;
  localparam int STABLE = 3;

  localparam logic [63:0] G_DIAG  = 64'h8040_2010_0804_0201;
  localparam logic [63:0] G_ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] G_ROW0  = 64'h0000_0000_0000_00FF;
  localparam logic [63:0] G_MIX   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] G_BLOCK = 64'h0000_0018_1800_0000;

  logic clk;
  logic reset;

  life_matrix_scan_if bus_if ();

  life_matrix_scan #(
    .ROW_CYCLES    (ROWC),
    .BLANK_CYCLES  (BLANK),
    .STABLE_FRAMES (STABLE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Checks scan positions first..last of one frame against a front buffer.
  // After sampling position load_at, a one-cycle grid_load is driven so it
  // is seen by the edge at position load_at+1.
  task automatic check_span(input int first, input int last, input logic [63:0] exp_front,
                            input int load_at, input logic [63:0] load_grid,
                            input logic stable_mid, input logic stable_end);
    for (int p = first; p <= last; p++) begin
      int         r;
      int         d;
      logic [7:0] exp_sel;
      logic [7:0] exp_col;
      @(negedge clk);
      bus_if.grid_load = 1'b0;
      r       = p / ROWC;
      d       = p % ROWC;
      exp_sel = 8'h01 << r;
      exp_col = (d < BLANK) ? 8'h00 : exp_front[r*8 +: 8];
      if (p == 63) exp_count++;
      check($sformatf("row_sel p%0d", p), 64'(bus_if.row_sel), 64'(exp_sel));
      check($sformatf("col_out p%0d", p), 64'(bus_if.col_out), 64'(exp_col));
      check($sformatf("frame_done p%0d", p), 64'(bus_if.frame_done), 64'(p == 63));
      check($sformatf("frame_count p%0d", p), 64'(bus_if.frame_count), 64'(exp_count[15:0]));
      check($sformatf("stable p%0d", p), 64'(bus_if.stable),
            64'((p == 63) ? stable_end : stable_mid));
      if (p == load_at) begin
        bus_if.grid      = load_grid;
        bus_if.grid_load = 1'b1;
      end
    end
  endtask

  task automatic check_dark(input string tag);
    check({tag, " row_sel"}, 64'(bus_if.row_sel), 64'h0);
    check({tag, " col_out"}, 64'(bus_if.col_out), 64'h0);
    check({tag, " frame_done"}, 64'(bus_if.frame_done), 64'h0);
    check({tag, " frame_count"}, 64'(bus_if.frame_count), 64'(exp_count[15:0]));
    check({tag, " stable"}, 64'(bus_if.stable), 64'h0);
  endtask

  typedef struct {
    int          load_at;   // -1: no load during this frame
    logic [63:0] load_grid;
    logic [63:0] exp_front; // grid expected on the matrix this frame
    logic        stable_mid;
    logic        stable_end;
  } frame_vec_t;

  frame_vec_t vecs[12];
  frame_vec_t still_vecs[6];

  initial begin
    // Frames 0..6: nothing loaded, dark. Frame 7 loads the diagonal.
    for (int i = 0; i < 7; i++) vecs[i] = '{-1, 64'h0, 64'h0, 1'b0, 1'b0};
    vecs[7]  = '{10, G_DIAG, 64'h0,  1'b0, 1'b0};
    // Load during row 3: the rest of this frame keeps the diagonal.
    vecs[8]  = '{26, G_ONES, G_DIAG, 1'b0, 1'b0};
    // Load on the boundary clock (row 7, dwell 7): bypass to the front.
    vecs[9]  = '{62, G_ROW0, G_ONES, 1'b0, 1'b0};
    vecs[10] = '{-1, 64'h0,  G_ROW0, 1'b0, 1'b0};
    vecs[11] = '{30, G_MIX,  G_ROW0, 1'b0, 1'b0};

    // Identical block loaded before four boundaries, then a different grid.
    still_vecs[0] = '{10, G_BLOCK, 64'h0,   1'b0, 1'b0};
    still_vecs[1] = '{10, G_BLOCK, G_BLOCK, 1'b0, 1'b0};
    still_vecs[2] = '{10, G_BLOCK, G_BLOCK, 1'b0, 1'b0};
    still_vecs[3] = '{10, G_BLOCK, G_BLOCK, 1'b0, 1'b1};
    still_vecs[4] = '{10, G_ONES,  G_BLOCK, 1'b1, 1'b0};
    still_vecs[5] = '{-1, 64'h0,   G_ONES,  1'b0, 1'b0};

    // Reset held with a load request active: everything stays cleared.
    reset            = 1'b0;
    bus_if.enable    = 1'b1;
    bus_if.grid      = G_ONES;
    bus_if.grid_load = 1'b1;
    repeat (3) @(negedge clk);
    check_dark("reset");

    bus_if.grid_load = 1'b0;
    reset            = 1'b1;

    foreach (vecs[i]) begin
      check_span(0, 63, vecs[i].exp_front, vecs[i].load_at, vecs[i].load_grid,
                 vecs[i].stable_mid, vecs[i].stable_end);
    end

    // Enable dropped for 20 clocks at row 5, dwell 3 (position 43).
    check_span(0, 42, G_MIX, -1, 64'h0, 1'b0, 1'b0);
    bus_if.enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_dark($sformatf("disabled k%0d", k));
    end
    bus_if.enable = 1'b1;
    check_span(43, 63, G_MIX, -1, 64'h0, 1'b0, 1'b0);

    // Reset mid-row 2 with a load pending; the pending load must be lost.
    check_span(0, 19, G_MIX, 5, G_ONES, 1'b0, 1'b0);
    #2 reset = 1'b0;
    exp_count = 0;
    #1 check_dark("async reset");
    @(negedge clk);
    check_dark("reset held");
    reset = 1'b1;
    check_span(0, 63, 64'h0, -1, 64'h0, 1'b0, 1'b0);
    check_span(0, 63, 64'h0, -1, 64'h0, 1'b0, 1'b0);

`ifdef LIFE_MATRIX_STABLE_DETECT_EN
    foreach (still_vecs[i]) begin
      check_span(0, 63, still_vecs[i].exp_front, still_vecs[i].load_at,
                 still_vecs[i].load_grid, still_vecs[i].stable_mid, still_vecs[i].stable_end);
    end
`else
    // Detector not built: stable must stay low even with a repeated grid.
    for (int i = 0; i < 5; i++) begin
      check_span(0, 63, still_vecs[i].exp_front, still_vecs[i].load_at,
                 still_vecs[i].load_grid, 1'b0, 1'b0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
